// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Bus bundle between a simple 16-bit core, the mem_responder and a
//   synchronous single-port RAM.
//
//   Core side   : req, we, addr[23:0], wdata[15:0]   (core -> responder)
//                 rdata[15:0], data_ready, busy, err  (responder -> core)
//   RAM side    : ram_en, ram_we, ram_addr, ram_din   (responder -> RAM)
//                 ram_dout                            (RAM -> responder)
//
//   Modports:
//     slave  - the responder.
//     master - everything around it: the core plus the RAM, which drives
//              ram_dout.
// ---------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int unsigned RAM_AW = 14
);
    // core handshake
    logic              req;
    logic              we;
    logic [23:0]       addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              data_ready;
    logic              busy;
    logic              err;

    // synchronous RAM port
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    modport slave (
        input  req, we, addr, wdata,
        output rdata, data_ready, busy, err,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output req, we, addr, wdata,
        input  rdata, data_ready, busy, err,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-outstanding memory responder for a 16-bit core. A request is
//   accepted only in IDLE, held in ACCESS for WAIT_STATES+1 cycles, and
//   completed with a one-cycle RESP (data_ready). The latched word address
//   decodes to:
//     RAM           addr <  2**RAM_AW   -> synchronous RAM port
//     IO            addr == IO_ADDR     -> 16-bit display register
//     out-of-range  anything else       -> writes dropped, reads return 0,
//                                          err pulses with data_ready
//
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous, active-low
//     bus      mem_responder_if.slave (core handshake + RAM port)
//     display  display register contents (seven-segment mux)
//
//   Latency: request accepted in cycle 0 -> data_ready in cycle
//   WAIT_STATES+2; back-to-back period is WAIT_STATES+3 cycles.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned WAIT_STATES = 1,            // 1..15
    parameter int unsigned RAM_AW      = 14,
    parameter logic [23:0] IO_ADDR     = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    output logic [15:0]           display
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One past the last RAM word; 25 bits so RAM_AW up to 24 still compares.
    localparam logic [24:0] RAM_LIMIT = 25'd1 << RAM_AW;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;

    // request latched at accept
    logic        we_q;
    logic [23:0] addr_q;
    logic [15:0] wdata_q;

    logic [15:0] rdata_q;
    logic [15:0] display_q;

    logic        accept;      // IDLE -> ACCESS this cycle
    logic        finish;      // ACCESS -> RESP this cycle
    logic        is_ram;
    logic        is_io;
    logic        is_oor;
    logic        first_access;

    logic        busy_c;
    logic        data_ready_c;
    logic        err_c;
    logic        ram_en_c;
    logic        ram_we_c;

    // -----------------------------------------------------------------------
    // Address decode on the latched address. RAM wins if IO_ADDR were ever
    // configured inside the RAM window.
    // -----------------------------------------------------------------------
    always_comb begin
        is_ram = ({1'b0, addr_q} < RAM_LIMIT);
        is_io  = !is_ram && (addr_q == IO_ADDR);
        is_oor = !is_ram && !is_io;
    end

    // The counter only equals its load value in the first ACCESS cycle,
    // because it is decremented every cycle and WAIT_STATES >= 1.
    assign first_access = (wait_cnt == WAIT_INIT);

    // -----------------------------------------------------------------------
    // FSM: next state, counter and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        finish       = 1'b0;
        busy_c       = 1'b0;
        data_ready_c = 1'b0;
        err_c        = 1'b0;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = WAIT_INIT;
                    accept       = 1'b1;
                end
            end

            ACCESS: begin
                busy_c   = 1'b1;
                ram_en_c = is_ram;
                // a single write strobe is enough for a synchronous RAM
                ram_we_c = is_ram && we_q && first_access;
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                    finish    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end

            RESP: begin
                busy_c       = 1'b1;
                data_ready_c = 1'b1;
                err_c        = is_oor;
                state_nxt    = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 24'd0;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
            display_q <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;

            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end

            // All results land on the ACCESS->RESP edge. ram_dout is valid
            // here because ram_en has been high since the first ACCESS cycle
            // and ACCESS is at least two cycles long.
            if (finish) begin
                if (is_ram && !we_q) begin
                    rdata_q <= bus.ram_dout;
                end
                if (is_io) begin
                    if (we_q) begin
                        display_q <= wdata_q;
                    end else begin
                        rdata_q <= display_q;
                    end
                end
                if (is_oor && !we_q) begin
                    rdata_q <= 16'h0000;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.rdata      = rdata_q;
    assign bus.data_ready = data_ready_c;
    assign bus.busy       = busy_c;
    assign bus.err        = err_c;
    assign bus.ram_en     = ram_en_c;
    assign bus.ram_we     = ram_we_c;
    assign bus.ram_addr   = addr_q[RAM_AW-1:0];
    assign bus.ram_din    = wdata_q;
    assign display        = display_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int          WS_A    = 1;
    localparam int          WS_B    = 15;
    localparam int          AW      = 14;
    localparam int          NWORDS  = 1 << AW;
    localparam logic [23:0] IO_A    = 24'hFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_init;
    logic        sel;              // 0: drive/observe dut_a, 1: dut_b
    logic        drv_req, drv_we;
    logic [23:0] drv_addr;
    logic [15:0] drv_wdata;
    logic [15:0] disp_a, disp_b;

    int n_cmp, n_bad;

    mem_responder_if #(.RAM_AW(AW)) if_a ();
    mem_responder_if #(.RAM_AW(AW)) if_b ();

    mem_responder #(.WAIT_STATES(WS_A), .RAM_AW(AW), .IO_ADDR(IO_A)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave), .display(disp_a));
    mem_responder #(.WAIT_STATES(WS_B), .RAM_AW(AW), .IO_ADDR(IO_A)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave), .display(disp_b));

    assign if_a.req   = sel ? 1'b0 : drv_req;
    assign if_b.req   = sel ? drv_req : 1'b0;
    assign if_a.we    = drv_we;
    assign if_b.we    = drv_we;
    assign if_a.addr  = drv_addr;
    assign if_b.addr  = drv_addr;
    assign if_a.wdata = drv_wdata;
    assign if_b.wdata = drv_wdata;

    logic        obs_busy, obs_dr, obs_err, obs_en, obs_we;
    logic [15:0] obs_rdata, obs_disp;
    assign obs_busy  = sel ? if_b.busy       : if_a.busy;
    assign obs_dr    = sel ? if_b.data_ready : if_a.data_ready;
    assign obs_err   = sel ? if_b.err        : if_a.err;
    assign obs_en    = sel ? if_b.ram_en     : if_a.ram_en;
    assign obs_we    = sel ? if_b.ram_we     : if_a.ram_we;
    assign obs_rdata = sel ? if_b.rdata      : if_a.rdata;
    assign obs_disp  = sel ? disp_b          : disp_a;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 7 + 16'h1357);
    endfunction

    // synchronous RAM models
    logic [15:0] mem_a [0:NWORDS-1];
    logic [15:0] mem_b [0:NWORDS-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NWORDS; i++) mem_a[i] <= init_word(i);
        end else if (if_a.ram_en) begin
            if (if_a.ram_we) mem_a[if_a.ram_addr] <= if_a.ram_din;
            if_a.ram_dout <= mem_a[if_a.ram_addr];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NWORDS; i++) mem_b[i] <= init_word(i);
        end else if (if_b.ram_en) begin
            if (if_b.ram_we) mem_b[if_b.ram_addr] <= if_b.ram_din;
            if_b.ram_dout <= mem_b[if_b.ram_addr];
        end
    end

    // reference model state for dut_a
    logic [15:0] ref_mem [int];
    logic [15:0] ref_rdata, ref_disp;

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Presents one request to an idle DUT (cycle 0) and observes it until
    // data_ready (bounded), then steps into the following IDLE cycle.
    task automatic do_xfer(input logic w, input logic [23:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output logic e,
                           output logic [15:0] disp, output int we_cnt, output int en_cnt);
        drv_req = 1'b1; drv_we = w; drv_addr = a; drv_wdata = d;
        tick();
        drv_req = 1'b0;
        lat = -1; we_cnt = 0; en_cnt = 0; rd = '0; e = 1'b0; disp = '0;
        for (int c = 1; c <= 40; c++) begin
            if (obs_we) we_cnt++;
            if (obs_en) en_cnt++;
            if (obs_dr) begin
                lat = c; rd = obs_rdata; e = obs_err; disp = obs_disp;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        sel = 1'b0; reset = 1'b0; mem_init = 1'b1; drv_req = 1'b1;
        drv_we = 1'b0; drv_addr = 24'd5; drv_wdata = 16'h0;
        repeat (3) tick();
        mem_init = 1'b0;
        n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
        n_cmp++; if (if_a.data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_dr: got %b want 0", if_a.data_ready); end
        n_cmp++; if (if_a.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", if_a.err); end
        n_cmp++; if (if_a.rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", if_a.rdata); end
        n_cmp++; if (disp_a !== 16'h0) begin n_bad++; $display("FAIL reset_display: got %h want 0000", disp_a); end
        n_cmp++; if (if_a.ram_en !== 1'b0 || if_a.ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram: got en=%b we=%b want 0/0", if_a.ram_en, if_a.ram_we); end
        n_cmp++; if (if_b.busy !== 1'b0 || disp_b !== 16'h0) begin n_bad++; $display("FAIL reset_b: got busy=%b disp=%h want 0/0000", if_b.busy, disp_b); end
        reset = 1'b1; drv_req = 1'b0;
        tick();
        n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", if_a.busy); end
        ref_rdata = 16'h0; ref_disp = 16'h0;
    endtask

    task automatic test_ram_wr_rd();
        int lat, wc, ec; logic [15:0] rd, dp; logic e;
        sel = 1'b0;
        do_xfer(1'b1, 24'd9216, 16'hA5C3, lat, rd, e, dp, wc, ec);
        ref_mem[9216] = 16'hA5C3;
        n_cmp++; if (lat !== WS_A + 2) begin n_bad++; $display("FAIL ram_wr_lat: got %0d want %0d", lat, WS_A + 2); end
        n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL ram_wr_we_pulses: got %0d want 1", wc); end
        n_cmp++; if (ec !== WS_A + 1) begin n_bad++; $display("FAIL ram_wr_en_cycles: got %0d want %0d", ec, WS_A + 1); end
        n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL ram_wr_rdata_held: got %h want %h", rd, ref_rdata); end
        n_cmp++; if (mem_a[9216] !== 16'hA5C3) begin n_bad++; $display("FAIL ram_wr_mem: got %h want a5c3", mem_a[9216]); end
        do_xfer(1'b0, 24'd9216, 16'h0, lat, rd, e, dp, wc, ec);
        ref_rdata = 16'hA5C3;
        n_cmp++; if (lat !== WS_A + 2) begin n_bad++; $display("FAIL ram_rd_lat: got %0d want %0d", lat, WS_A + 2); end
        n_cmp++; if (rd !== 16'hA5C3) begin n_bad++; $display("FAIL ram_rd_data: got %h want a5c3", rd); end
        n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL ram_rd_we: got %0d want 0", wc); end
    endtask

    task automatic test_io();
        int lat, wc, ec; logic [15:0] rd, dp; logic e;
        sel = 1'b0;
        do_xfer(1'b1, IO_A, 16'h1234, lat, rd, e, dp, wc, ec);
        ref_disp = 16'h1234;
        n_cmp++; if (lat !== WS_A + 2) begin n_bad++; $display("FAIL io_wr_lat: got %0d want %0d", lat, WS_A + 2); end
        n_cmp++; if (dp !== 16'h1234) begin n_bad++; $display("FAIL io_wr_display: got %h want 1234", dp); end
        n_cmp++; if (ec !== 0 || wc !== 0) begin n_bad++; $display("FAIL io_wr_ram_idle: got en=%0d we=%0d want 0/0", ec, wc); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL io_wr_err: got %b want 0", e); end
        do_xfer(1'b0, IO_A, 16'h0, lat, rd, e, dp, wc, ec);
        ref_rdata = 16'h1234;
        n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL io_rd_data: got %h want 1234", rd); end
        n_cmp++; if (ec !== 0) begin n_bad++; $display("FAIL io_rd_ram_en: got %0d want 0", ec); end
    endtask

    task automatic test_oor();
        int lat, wc, ec; logic [15:0] rd, dp; logic e;
        sel = 1'b0;
        do_xfer(1'b1, 24'h800000, 16'hFFFF, lat, rd, e, dp, wc, ec);
        n_cmp++; if (e !== 1'b1 || lat !== WS_A + 2) begin n_bad++; $display("FAIL oor_wr_err: got err=%b lat=%0d want 1/%0d", e, lat, WS_A + 2); end
        n_cmp++; if (ec !== 0 || wc !== 0) begin n_bad++; $display("FAIL oor_wr_ram_idle: got en=%0d we=%0d want 0/0", ec, wc); end
        n_cmp++; if (mem_a[0] !== ref_rd(0)) begin n_bad++; $display("FAIL oor_wr_mem: got %h want %h", mem_a[0], ref_rd(0)); end
        n_cmp++; if (dp !== ref_disp) begin n_bad++; $display("FAIL oor_wr_display: got %h want %h", dp, ref_disp); end
        n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL oor_wr_rdata_held: got %h want %h", rd, ref_rdata); end
        do_xfer(1'b0, 24'h800000, 16'h0, lat, rd, e, dp, wc, ec);
        ref_rdata = 16'h0000;
        n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL oor_rd_data: got %h want 0000", rd); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b want 1", e); end
    endtask

    task automatic test_back_to_back();
        int p = WS_A + 3;
        sel = 1'b0;
        drv_req = 1'b1; drv_we = 1'b0; drv_addr = 24'd9216;
        for (int c = 0; c < 5 * p; c++) begin
            n_cmp++; if (obs_busy !== ((c % p) != 0)) begin n_bad++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, obs_busy, (c % p) != 0); end
            n_cmp++; if (obs_dr !== ((c % p) == p - 1)) begin n_bad++; $display("FAIL b2b_dr c=%0d: got %b want %b", c, obs_dr, (c % p) == p - 1); end
            if ((c % p) == p - 1) begin
                n_cmp++; if (obs_rdata !== 16'hA5C3) begin n_bad++; $display("FAIL b2b_rdata c=%0d: got %h want a5c3", c, obs_rdata); end
            end
            tick();
        end
        drv_req = 1'b0;
        ref_rdata = 16'hA5C3;
    endtask

    task automatic test_reset_mid();
        int drs;
        sel = 1'b0;
        drv_req = 1'b1; drv_we = 1'b1; drv_addr = IO_A; drv_wdata = 16'hBEEF;
        tick();                       // cycle 1: first ACCESS
        drv_req = 1'b0;
        tick();                       // cycle 2: second ACCESS
        n_cmp++; if (obs_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", obs_busy); end
        reset = 1'b0; drv_req = 1'b1;
        tick();
        ref_disp = 16'h0; ref_rdata = 16'h0;
        n_cmp++; if (obs_busy !== 1'b0 || obs_dr !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got busy=%b dr=%b want 0/0", obs_busy, obs_dr); end
        n_cmp++; if (obs_disp !== 16'h0) begin n_bad++; $display("FAIL rstmid_display: got %h want 0000", obs_disp); end
        n_cmp++; if (obs_we !== 1'b0 || obs_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_ram: got en=%b we=%b want 0/0", obs_en, obs_we); end
        tick();
        n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_req_ignored: got busy=%b want 0", obs_busy); end
        reset = 1'b1; drv_req = 1'b0;
        drs = 0;
        repeat (6) begin tick(); if (obs_dr) drs++; end
        n_cmp++; if (drs !== 0) begin n_bad++; $display("FAIL rstmid_no_dr: got %0d pulses want 0", drs); end
        n_cmp++; if (obs_disp !== 16'h0) begin n_bad++; $display("FAIL rstmid_display_after: got %h want 0000", obs_disp); end
    endtask

    task automatic test_random();
        int lat, wc, ec, kind; logic [15:0] rd, dp, d; logic e, w, ram, oor;
        logic [23:0] a; logic [23:0] pool [8];
        sel = 1'b0;
        for (int i = 0; i < 8; i++) pool[i] = 24'($urandom_range(0, NWORDS - 1));
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (kind <= 5)      a = pool[$urandom_range(0, 7)];
            else if (kind <= 7) a = IO_A;
            else                a = 24'(NWORDS + $urandom_range(0, 24'hFFFFFE - NWORDS));
            ram = (a < NWORDS);
            oor = !ram && (a != IO_A);
            do_xfer(w, a, d, lat, rd, e, dp, wc, ec);
            if (ram) begin
                if (w) ref_mem[int'(a)] = d; else ref_rdata = ref_rd(int'(a));
            end else if (!oor) begin
                if (w) ref_disp = d; else ref_rdata = ref_disp;
            end else if (!w) begin
                ref_rdata = 16'h0;
            end
            n_cmp++; if (lat !== WS_A + 2) begin n_bad++; $display("FAIL rnd%0d_lat: got %0d want %0d", t, lat, WS_A + 2); end
            n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL rnd%0d_rdata a=%h we=%b: got %h want %h", t, a, w, rd, ref_rdata); end
            n_cmp++; if (e !== oor) begin n_bad++; $display("FAIL rnd%0d_err a=%h: got %b want %b", t, a, e, oor); end
            n_cmp++; if (dp !== ref_disp) begin n_bad++; $display("FAIL rnd%0d_display: got %h want %h", t, dp, ref_disp); end
            n_cmp++; if (wc !== ((ram && w) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_ram_we: got %0d want %0d", t, wc, (ram && w) ? 1 : 0); end
            n_cmp++; if (ec !== (ram ? WS_A + 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_ram_en: got %0d want %0d", t, ec, ram ? WS_A + 1 : 0); end
        end
    endtask

    task automatic test_wait_sweep();
        int lat, wc, ec; logic [15:0] rd, dp; logic e;
        sel = 1'b1;
        do_xfer(1'b0, 24'd9216, 16'h0, lat, rd, e, dp, wc, ec);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL ws15_rd_lat: got %0d want 17", lat); end
        n_cmp++; if (ec !== 16) begin n_bad++; $display("FAIL ws15_rd_access_cycles: got %0d want 16", ec); end
        n_cmp++; if (rd !== init_word(9216)) begin n_bad++; $display("FAIL ws15_rd_data: got %h want %h", rd, init_word(9216)); end
        do_xfer(1'b1, 24'd100, 16'h7E81, lat, rd, e, dp, wc, ec);
        n_cmp++; if (lat !== 17 || wc !== 1) begin n_bad++; $display("FAIL ws15_wr: got lat=%0d we=%0d want 17/1", lat, wc); end
        do_xfer(1'b0, 24'd100, 16'h0, lat, rd, e, dp, wc, ec);
        n_cmp++; if (rd !== 16'h7E81) begin n_bad++; $display("FAIL ws15_rd_back: got %h want 7e81", rd); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        sel = 1'b0; drv_req = 1'b0; drv_we = 1'b0; drv_addr = '0; drv_wdata = '0;
        reset = 1'b0; mem_init = 1'b1;
        test_reset();
        test_ram_wr_rd();
        test_io();
        test_oor();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wait_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
